mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//  Multicycle signed MULT/DIV responder for the CPU datapath. Accepts a one-cycle
//  start from the control unit, with operands taken from regs A/B, and iterates one bit per cycle.
//  Returns a 64-bit result as hi/lo, which feeds the HI/LO register loads, plus a done pulse
//  and a DIV0 flag that drives the divide-by-zero exception path.
// PARAMETERS
//  WIDTH    32   operand width; hi/lo are WIDTH bits each
//  CNT_W    6    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk      in   1      single clock; all state updates on rising edge
//  reset    in   1      asynchronous, active-low; 0 forces the reset state immediately
//  start    in   1      request pulse; sampled only in IDLE
//  op       in   1      0 = MULT, 1 = DIV; sampled with start
//  a        in   WIDTH  multiplicand / dividend (signed)
//  b        in   WIDTH  multiplier / divisor (signed)
//  hi       out  WIDTH  MULT: product[63:32]; DIV: remainder
//  lo       out  WIDTH  MULT: product[31:0];  DIV: quotient
//  busy     out  1      high from the cycle after acceptance until done
//  done     out  1      one-cycle pulse; hi/lo are valid in that cycle
//  div0     out  1      one-cycle pulse, coincident with done, for DIV with b==0
// BEHAVIOUR
//  Reset (reset=0): state=IDLE, hi=lo=0, busy=done=div0=0, counter=0. Takes effect mid-operation
//   too: the operation is aborted, no done is produced, and partial results are discarded.
//  FSM: IDLE, MULT, DIV, FIX, DONE, ERR.
//   IDLE: start=1 at edge N -> latch op, a, b, and |a|,|b| and sign flags as needed.
//         op=0 -> MULT; op=1 & b!=0 -> DIV; op=1 & b==0 -> ERR.
//   MULT: radix-2 Booth, 65-bit product register {acc, mult, q-1}.
//         WIDTH iterations of add/sub then arithmetic shift right 1 -> DONE.
//   DIV:  restoring division on magnitudes, WIDTH iterations -> FIX.
//   FIX:  quotient negated iff sign(a)!=sign(b); remainder negated iff a<0 -> DONE.
//   DONE: hi/lo loaded; done=1, busy=0 -> IDLE.
//   ERR:  done=1, div0=1; hi/lo keep their previous values -> IDLE.
//  Latency (start sampled at edge N): MULT done high after edge N+33; DIV after edge N+34;
//   div-by-zero after edge N+1. busy is high from N+1 through the last iteration or FIX cycle.
//  hi/lo hold their value between operations and change only on entry to DONE.
//  start outside IDLE is ignored (no queueing). A new start is accepted in the cycle after done.
//  Arithmetic: both ops are signed two's complement. Division truncates toward zero.
//   Remainder takes the sign of the dividend.
//  Overflow case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No div0, no other flag.
//  Magnitude of 0x80000000 is held in WIDTH+1 bits internally; no intermediate truncation.
//  Inputs a, b, and op are not required to be stable after the start cycle.
// STRUCTURE
//  Shared package mdu_pkg:
//   - state enum (IDLE, MULT, DIV, FIX, DONE, ERR)
//   - OP_MULT=1'b0, OP_DIV=1'b1
//   - ITER=WIDTH
//  Sub-module mdu_div_core: one restoring-division step, combinational.
//   Inputs: partial remainder, divisor. Outputs: next remainder, quotient bit.
//   Instantiated once in this block.
//  The Booth step, counter, FSM, and sign fix-up stay in this top block.
// TESTING
//  1. MULT a=7, b=-3 (0xFFFFFFFD) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, done exactly 33 cycles
//     after the start edge, busy high for 32 cycles.
//  2. MULT a=b=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001.
//  3. DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), done at 34 cycles.
//     DIV a=7, b=-2 -> lo=-3, hi=1.
//  4. DIV a=5, b=0 with prior hi/lo=0x11/0x22 -> done=div0=1 one cycle after the start edge,
//     hi/lo remain 0x11/0x22, busy never high.
//  5. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div0=0.
//  6. start pulses while busy are ignored (single done, result of first op).
//     reset=0 at iteration 10 -> hi=lo=0, busy=0 immediately, no done.
//     A fresh MULT 3*4 after reset -> lo=12.
//  Bench also compares every op against a reference model on random signed a/b, with b!=0 for DIV.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and constants for the multicycle signed multiply/divide unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MULT = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_e;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int ITER = 32;

endpackage

// File: rtl/mdu_div_core.sv
// One restoring-division step on unsigned magnitudes: trial subtract, keep or restore.
module mdu_div_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = ITER
) (
    input  logic [WIDTH:0]   part_rem,
    input  logic [WIDTH:0]   divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH+1:0] diff;
    logic             unused_diff_bit;

    // A kept difference is below the divisor (at most 2**(WIDTH-1)), so WIDTH bits hold it.
    always_comb begin
        diff     = {1'b0, part_rem} - {1'b0, divisor};
        q_bit    = ~diff[WIDTH+1];
        next_rem = q_bit ? diff[WIDTH-1:0] : part_rem[WIDTH-1:0];
    end

    assign unused_diff_bit = diff[WIDTH];

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT (radix-2 Booth) / DIV (restoring) unit producing HI/LO,
// a done pulse and a divide-by-zero flag.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = ITER,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div0
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e                  state;
    logic [CNT_W-1:0]        cnt;
    logic                    op_q;

    logic signed [WIDTH:0]   acc_q;
    logic signed [WIDTH:0]   mcand_q;
    logic signed [WIDTH:0]   acc_sum;
    logic [WIDTH-1:0]        mplr_q;
    logic                    qm1_q;

    logic [WIDTH-1:0]        rem_q;
    logic [WIDTH-1:0]        quo_q;
    logic [WIDTH-1:0]        rem_nxt;
    logic                    q_bit;
    logic [WIDTH:0]          dvsr_q;
    logic [WIDTH:0]          mag_a;
    logic [WIDTH:0]          mag_b;
    logic                    neg_quo_q;
    logic                    neg_rem_q;
    logic                    unused_mag_msb;

    function automatic logic [WIDTH:0] mag(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] ext;
        ext = {v[WIDTH-1], v};
        return v[WIDTH-1] ? -ext : ext;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign mag_a          = mag(a);
    assign mag_b          = mag(b);
    // |a| never exceeds 2**(WIDTH-1), so it seeds the WIDTH-bit quotient register directly.
    assign unused_mag_msb = mag_a[WIDTH];

    // The accumulator carries one guard bit so the most negative multiplicand cannot overflow.
    always_comb begin
        acc_sum = acc_q;
        case ({mplr_q[0], qm1_q})
            2'b01:   acc_sum = acc_q + mcand_q;
            2'b10:   acc_sum = acc_q - mcand_q;
            default: acc_sum = acc_q;
        endcase
    end

    mdu_div_core #(
        .WIDTH(WIDTH)
    ) u_div_core (
        .part_rem({rem_q, quo_q[WIDTH-1]}),
        .divisor (dvsr_q),
        .next_rem(rem_nxt),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= OP_MULT;
            busy  <= 1'b0;
            done  <= 1'b0;
            div0  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            div0 <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= op;
                        cnt  <= '0;
                        if (op == OP_MULT) begin
                            state <= MULT;
                        end else if (b == '0) begin
                            state <= ERR;
                        end else begin
                            state <= DIV;
                        end
                    end
                end
                MULT: begin
                    busy <= 1'b1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state <= DONE;
                    end
                end
                DIV: begin
                    busy <= 1'b1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    busy  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                    if (op_q == OP_MULT) begin
                        hi <= acc_q[WIDTH-1:0];
                        lo <= mplr_q;
                    end else begin
                        hi <= rem_q;
                        lo <= quo_q;
                    end
                end
                ERR: begin
                    done  <= 1'b1;
                    div0  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (start) begin
                    acc_q     <= '0;
                    mcand_q   <= {a[WIDTH-1], a};
                    mplr_q    <= b;
                    qm1_q     <= 1'b0;
                    rem_q     <= '0;
                    quo_q     <= mag_a[WIDTH-1:0];
                    dvsr_q    <= mag_b;
                    neg_quo_q <= a[WIDTH-1] ^ b[WIDTH-1];
                    neg_rem_q <= a[WIDTH-1];
                end
            end
            MULT: begin
                acc_q  <= {acc_sum[WIDTH], acc_sum[WIDTH:1]};
                mplr_q <= {acc_sum[0], mplr_q[WIDTH-1:1]};
                qm1_q  <= mplr_q[0];
            end
            DIV: begin
                rem_q <= rem_nxt;
                quo_q <= {quo_q[WIDTH-2:0], q_bit};
            end
            FIX: begin
                quo_q <= cond_neg(quo_q, neg_quo_q);
                rem_q <= cond_neg(rem_q, neg_rem_q);
            end
            default: begin
            end
        endcase
    end

endmodule
